// File: rtl/issue_scheduler.sv
// issue_scheduler: two-wide oldest-first wakeup/select issue queue that also drives busy-table select-clear tags.
// Define ISSUE_SPEC_WAKEUP_EN to make the issued dest tags wake dependents too, giving back-to-back issue.
module issue_scheduler #(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_flush,
    input  logic                 i_disp1_valid,
    input  logic                 i_disp2_valid,
    input  logic [4:0]           i_disp1_src1,
    input  logic [4:0]           i_disp1_src2,
    input  logic [4:0]           i_disp1_dest,
    input  logic [4:0]           i_disp2_src1,
    input  logic [4:0]           i_disp2_src2,
    input  logic [4:0]           i_disp2_dest,
    input  logic                 i_disp1_src1_ready,
    input  logic                 i_disp1_src2_ready,
    input  logic                 i_disp2_src1_ready,
    input  logic                 i_disp2_src2_ready,
    input  logic                 i_disp1_rf_we,
    input  logic                 i_disp2_rf_we,
    input  logic [PAYLOAD_W-1:0] i_disp1_payload,
    input  logic [PAYLOAD_W-1:0] i_disp2_payload,
    output logic                 o_disp_ready,
    output logic                 o_issue1_valid,
    output logic                 o_issue2_valid,
    input  logic                 i_issue1_ready,
    input  logic                 i_issue2_ready,
    output logic [PAYLOAD_W-1:0] o_issue1_payload,
    output logic [PAYLOAD_W-1:0] o_issue2_payload,
    output logic [4:0]           o_sel_inst1_dest,
    output logic [4:0]           o_sel_inst2_dest,
    input  logic [4:0]           i_wb_inst1_dest,
    input  logic [4:0]           i_wb_inst2_dest
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]           s1;
        logic                 r1;
        logic [4:0]           s2;
        logic                 r2;
        logic [4:0]           dst;
        logic                 we;
        logic [PAYLOAD_W-1:0] pl;
    } entry_t;

    entry_t        r_q  [DEPTH];
    entry_t        w_nq [DEPTH];
    logic [CW-1:0] r_count, w_count_n;
    logic [DEPTH-1:0] w_rdy, w_iss;
    logic [IW-1:0] w_a, w_b, w_i2;
    logic [4:0]    w_t3, w_t4;
    logic [19:0]   w_tags;
    logic          w_kill, w_fa, w_fb, w_v1, w_v2, w_acc1, w_acc2;

    function automatic logic hit(input logic [4:0] t, input logic [19:0] tg);
        return t != 5'd0 && (t == tg[4:0] || t == tg[9:5] || t == tg[14:10] || t == tg[19:15]);
    endfunction

    function automatic entry_t mk(input logic [4:0] s1, input logic r1, input logic [4:0] s2,
                                  input logic r2, input logic [4:0] d, input logic we,
                                  input logic [PAYLOAD_W-1:0] pl, input logic [19:0] tg);
        mk = '{s1: s1, r1: r1 || s1 == 5'd0 || hit(s1, tg),
               s2: s2, r2: r2 || s2 == 5'd0 || hit(s2, tg),
               dst: d, we: we, pl: pl};
    endfunction

`ifdef ISSUE_SPEC_WAKEUP_EN
    assign w_t3 = o_sel_inst1_dest;
    assign w_t4 = o_sel_inst2_dest;
`else
    assign w_t3 = 5'd0;
    assign w_t4 = 5'd0;
`endif
    assign w_tags = {w_t4, w_t3, i_wb_inst2_dest, i_wb_inst1_dest};

    always_comb begin
        for (int i = 0; i < DEPTH; i++) w_rdy[i] = CW'(i) < r_count && r_q[i].r1 && r_q[i].r2;
    end

    // Entry 0 is oldest, so the first two ready slots found upward are the two oldest ready instructions.
    always_comb begin
        w_fa = 1'b0;
        w_fb = 1'b0;
        w_a  = '0;
        w_b  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_rdy[i] && !w_fa) begin
                w_fa = 1'b1;
                w_a  = IW'(i);
            end else if (w_rdy[i] && !w_fb) begin
                w_fb = 1'b1;
                w_b  = IW'(i);
            end
        end
    end

    assign w_kill           = reset || i_flush;
    assign w_i2             = i_issue1_ready ? w_b : w_a;
    assign w_v1             = !w_kill && i_issue1_ready && w_fa;
    assign w_v2             = !w_kill && i_issue2_ready && (i_issue1_ready ? w_fb : w_fa);
    assign o_issue1_valid   = w_v1;
    assign o_issue2_valid   = w_v2;
    assign o_issue1_payload = w_v1 ? r_q[w_a].pl : '0;
    assign o_issue2_payload = w_v2 ? r_q[w_i2].pl : '0;
    assign o_sel_inst1_dest = (w_v1 && r_q[w_a].we) ? r_q[w_a].dst : 5'd0;
    assign o_sel_inst2_dest = (w_v2 && r_q[w_i2].we) ? r_q[w_i2].dst : 5'd0;
    assign o_disp_ready     = r_count <= CW'(DEPTH - 2);
    assign w_acc1           = !w_kill && o_disp_ready && i_disp1_valid;
    assign w_acc2           = !w_kill && o_disp_ready && i_disp2_valid;

    // Survivors compact downward in order with wakeup applied, then accepted dispatches append behind them.
    always_comb begin
        logic [CW-1:0] p;
        p    = '0;
        w_nq = r_q;
        for (int i = 0; i < DEPTH; i++) begin
            w_iss[i] = (w_v1 && w_a == IW'(i)) || (w_v2 && w_i2 == IW'(i));
            if (CW'(i) < r_count && !w_iss[i]) begin
                w_nq[p[IW-1:0]]    = r_q[i];
                w_nq[p[IW-1:0]].r1 = r_q[i].r1 || hit(r_q[i].s1, w_tags);
                w_nq[p[IW-1:0]].r2 = r_q[i].r2 || hit(r_q[i].s2, w_tags);
                p = p + CW'(1);
            end
        end
        if (w_acc1) begin
            w_nq[p[IW-1:0]] = mk(i_disp1_src1, i_disp1_src1_ready, i_disp1_src2, i_disp1_src2_ready,
                                 i_disp1_dest, i_disp1_rf_we, i_disp1_payload, w_tags);
            p = p + CW'(1);
        end
        if (w_acc2) begin
            w_nq[p[IW-1:0]] = mk(i_disp2_src1, i_disp2_src1_ready, i_disp2_src2, i_disp2_src2_ready,
                                 i_disp2_dest, i_disp2_rf_we, i_disp2_payload, w_tags);
            p = p + CW'(1);
        end
        w_count_n = p;
    end

    always_ff @(posedge clk) begin
        r_count <= w_kill ? '0 : w_count_n;
        r_q     <= w_nq;
    end
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed scenarios and a randomized run checked against a queue-based model.
`timescale 1ns/1ps
module tb_issue_scheduler;
    localparam int D  = 8;
    localparam int PW = 32;

    logic clk = 1'b0;
    logic reset, flush, d1v, d2v, d1r1, d1r2, d2r1, d2r2, d1we, d2we, ir1, ir2;
    logic [4:0] d1s1, d1s2, d1d, d2s1, d2s2, d2d, wb1, wb2, sel1, sel2;
    logic [PW-1:0] d1pl, d2pl, p1, p2;
    logic dr, v1, v2;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [4:0]    s1, s2, dst;
        bit            r1, r2, we;
        logic [PW-1:0] pl;
    } ment_t;

    always #5 clk = ~clk;

    issue_scheduler #(.DEPTH(D), .PAYLOAD_W(PW)) dut (
        .clk(clk), .reset(reset), .i_flush(flush),
        .i_disp1_valid(d1v), .i_disp2_valid(d2v),
        .i_disp1_src1(d1s1), .i_disp1_src2(d1s2), .i_disp1_dest(d1d),
        .i_disp2_src1(d2s1), .i_disp2_src2(d2s2), .i_disp2_dest(d2d),
        .i_disp1_src1_ready(d1r1), .i_disp1_src2_ready(d1r2),
        .i_disp2_src1_ready(d2r1), .i_disp2_src2_ready(d2r2),
        .i_disp1_rf_we(d1we), .i_disp2_rf_we(d2we),
        .i_disp1_payload(d1pl), .i_disp2_payload(d2pl),
        .o_disp_ready(dr), .o_issue1_valid(v1), .o_issue2_valid(v2),
        .i_issue1_ready(ir1), .i_issue2_ready(ir2),
        .o_issue1_payload(p1), .o_issue2_payload(p2),
        .o_sel_inst1_dest(sel1), .o_sel_inst2_dest(sel2),
        .i_wb_inst1_dest(wb1), .i_wb_inst2_dest(wb2)
    );

    function automatic bit hit(input logic [4:0] t, input logic [4:0] a, b, c, e);
        return t != 0 && (t == a || t == b || t == c || t == e);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        flush = 0; d1v = 0; d2v = 0; wb1 = 0; wb2 = 0;
    endtask

    task automatic disp1(input logic [4:0] s1, input logic r1, input logic [4:0] s2, input logic r2,
                         input logic [4:0] dd, input logic we, input logic [PW-1:0] pl);
        d1v = 1; d1s1 = s1; d1r1 = r1; d1s2 = s2; d1r2 = r2; d1d = dd; d1we = we; d1pl = pl;
    endtask

    task automatic disp2(input logic [4:0] s1, input logic r1, input logic [4:0] s2, input logic r2,
                         input logic [4:0] dd, input logic we, input logic [PW-1:0] pl);
        d2v = 1; d2s1 = s1; d2r1 = r1; d2s2 = s2; d2r2 = r2; d2d = dd; d2we = we; d2pl = pl;
    endtask

    task automatic clear_q;
        idle();
        flush = 1;
        tick();
        flush = 0;
    endtask

    task automatic test_reset;
        idle();
        reset = 1; ir1 = 1; ir2 = 1;
        disp1(0, 1, 0, 1, 3, 1, 32'hDEAD);
        tick();
        tick();
        total++; if (v1 !== 1'b0) begin bad++; $display("FAIL rst_during_v1 got=%0h exp=0", v1); end
        reset = 0;
        idle();
        #1;
        total++; if (dr !== 1'b1) begin bad++; $display("FAIL rst_disp_ready got=%0h exp=1", dr); end
        total++; if (v1 !== 1'b0) begin bad++; $display("FAIL rst_v1 got=%0h exp=0", v1); end
        total++; if (v2 !== 1'b0) begin bad++; $display("FAIL rst_v2 got=%0h exp=0", v2); end
        total++; if (p1 !== 32'h0) begin bad++; $display("FAIL rst_p1 got=%0h exp=0", p1); end
        total++; if (sel1 !== 5'd0 || sel2 !== 5'd0) begin bad++; $display("FAIL rst_sel got=%0d/%0d exp=0/0", sel1, sel2); end
    endtask

    task automatic test_two_ready;
        clear_q();
        ir1 = 1; ir2 = 1;
        disp1(0, 1, 0, 1, 3, 1, 32'hA1);
        disp2(0, 1, 0, 1, 4, 1, 32'hA2);
        #1;
        total++; if (v1 !== 1'b0) begin bad++; $display("FAIL two_same_cycle_v1 got=%0h exp=0", v1); end
        tick();
        idle();
        #1;
        total++; if (v1 !== 1'b1 || p1 !== 32'hA1) begin bad++; $display("FAIL two_issue1 got=%0h/%0h exp=1/a1", v1, p1); end
        total++; if (v2 !== 1'b1 || p2 !== 32'hA2) begin bad++; $display("FAIL two_issue2 got=%0h/%0h exp=1/a2", v2, p2); end
        total++; if (sel1 !== 5'd3 || sel2 !== 5'd4) begin bad++; $display("FAIL two_sel got=%0d/%0d exp=3/4", sel1, sel2); end
        tick();
        total++; if (v1 !== 1'b0 || v2 !== 1'b0 || dr !== 1'b1) begin bad++; $display("FAIL two_empty got=%0h%0h%0h exp=001", v1, v2, dr); end
    endtask

    task automatic test_wb_wakeup;
        clear_q();
        ir1 = 1; ir2 = 1;
        disp1(5, 0, 0, 1, 6, 1, 32'hB1);
        tick();
        idle();
        #1;
        total++; if (v1 !== 1'b0) begin bad++; $display("FAIL wb_early1 got=%0h exp=0", v1); end
        tick();
        wb1 = 5;
        #1;
        total++; if (v1 !== 1'b0) begin bad++; $display("FAIL wb_same_cycle got=%0h exp=0", v1); end
        tick();
        wb1 = 0;
        #1;
        total++; if (v1 !== 1'b1 || p1 !== 32'hB1 || sel1 !== 5'd6) begin bad++; $display("FAIL wb_issue got=%0h/%0h/%0d exp=1/b1/6", v1, p1, sel1); end
        tick();
        disp1(9, 0, 9, 0, 2, 1, 32'hB2);
        tick();
        idle();
        wb2 = 9;
        #1;
        total++; if (v1 !== 1'b0) begin bad++; $display("FAIL wb_both_early got=%0h exp=0", v1); end
        tick();
        wb2 = 0;
        #1;
        total++; if (v1 !== 1'b1 || p1 !== 32'hB2) begin bad++; $display("FAIL wb_both_issue got=%0h/%0h exp=1/b2", v1, p1); end
        tick();
    endtask

    task automatic test_full;
        clear_q();
        ir1 = 1; ir2 = 1;
        for (int k = 0; k < 3; k++) begin
            disp1(5'(10 + 2 * k), 0, 0, 1, 1, 1, 32'h100 + 32'(2 * k));
            disp2(5'(11 + 2 * k), 0, 0, 1, 1, 1, 32'h101 + 32'(2 * k));
            #1;
            total++; if (dr !== 1'b1) begin bad++; $display("FAIL full_fill_ready%0d got=%0h exp=1", k, dr); end
            tick();
        end
        idle();
        disp1(16, 0, 0, 1, 1, 1, 32'h106);
        tick();
        idle();
        disp1(17, 0, 0, 1, 1, 1, 32'h107);
        wb1 = 12;
        #1;
        total++; if (dr !== 1'b0) begin bad++; $display("FAIL full_ready_at7 got=%0h exp=0", dr); end
        total++; if (v1 !== 1'b0) begin bad++; $display("FAIL full_no_issue got=%0h exp=0", v1); end
        tick();
        idle();
        #1;
        total++; if (v1 !== 1'b1 || p1 !== 32'h102 || v2 !== 1'b0) begin bad++; $display("FAIL full_wake2 got=%0h/%0h/%0h exp=1/102/0", v1, p1, v2); end
        total++; if (dr !== 1'b0) begin bad++; $display("FAIL full_ready_still7 got=%0h exp=0", dr); end
        tick();
        wb1 = 10; wb2 = 13;
        #1;
        total++; if (dr !== 1'b1) begin bad++; $display("FAIL full_ready_after got=%0h exp=1", dr); end
        tick();
        idle();
        #1;
        total++; if (p1 !== 32'h100 || p2 !== 32'h103 || !v1 || !v2) begin bad++; $display("FAIL full_order got=%0h/%0h exp=100/103", p1, p2); end
        tick();
    endtask

    task automatic test_port2_only;
        clear_q();
        ir1 = 0; ir2 = 1;
        disp1(0, 1, 0, 1, 8, 1, 32'hC1);
        disp2(0, 1, 0, 1, 9, 1, 32'hC2);
        tick();
        idle();
        #1;
        total++; if (v1 !== 1'b0 || sel1 !== 5'd0) begin bad++; $display("FAIL p2_port1 got=%0h/%0d exp=0/0", v1, sel1); end
        total++; if (v2 !== 1'b1 || p2 !== 32'hC1 || sel2 !== 5'd8) begin bad++; $display("FAIL p2_oldest got=%0h/%0h/%0d exp=1/c1/8", v2, p2, sel2); end
        tick();
        total++; if (v2 !== 1'b1 || p2 !== 32'hC2 || sel2 !== 5'd9) begin bad++; $display("FAIL p2_younger got=%0h/%0h/%0d exp=1/c2/9", v2, p2, sel2); end
        tick();
        total++; if (v2 !== 1'b0) begin bad++; $display("FAIL p2_empty got=%0h exp=0", v2); end
        ir1 = 1;
    endtask

    task automatic test_back_to_back;
        clear_q();
        ir1 = 1; ir2 = 1;
        disp1(0, 1, 0, 1, 7, 1, 32'hD1);
        disp2(7, 0, 0, 1, 11, 1, 32'hD2);
        tick();
        idle();
        #1;
        total++; if (v1 !== 1'b1 || p1 !== 32'hD1 || sel1 !== 5'd7 || v2 !== 1'b0) begin bad++; $display("FAIL b2b_prod got=%0h/%0h/%0d/%0h exp=1/d1/7/0", v1, p1, sel1, v2); end
        tick();
`ifdef ISSUE_SPEC_WAKEUP_EN
        total++; if (v1 !== 1'b1 || p1 !== 32'hD2) begin bad++; $display("FAIL b2b_cons got=%0h/%0h exp=1/d2", v1, p1); end
        tick();
`else
        total++; if (v1 !== 1'b0) begin bad++; $display("FAIL b2b_cons_wait got=%0h exp=0", v1); end
        tick();
        wb2 = 7;
        #1;
        total++; if (v1 !== 1'b0) begin bad++; $display("FAIL b2b_wb_same got=%0h exp=0", v1); end
        tick();
        wb2 = 0;
        #1;
        total++; if (v1 !== 1'b1 || p1 !== 32'hD2) begin bad++; $display("FAIL b2b_cons got=%0h/%0h exp=1/d2", v1, p1); end
        tick();
`endif
    endtask

    task automatic test_flush;
        clear_q();
        ir1 = 0; ir2 = 0;
        disp1(0, 1, 0, 1, 1, 1, 32'hE0);
        disp2(0, 1, 0, 1, 2, 1, 32'hE1);
        tick();
        disp1(0, 1, 0, 1, 3, 1, 32'hE2);
        disp2(0, 1, 0, 1, 4, 1, 32'hE3);
        tick();
        idle();
        disp1(0, 1, 0, 1, 5, 1, 32'hE4);
        tick();
        idle();
        ir1 = 1; ir2 = 1; flush = 1;
        disp1(0, 1, 0, 1, 6, 1, 32'hE5);
        #1;
        total++; if (v1 !== 1'b0 || v2 !== 1'b0) begin bad++; $display("FAIL fl_valid got=%0h/%0h exp=0/0", v1, v2); end
        total++; if (sel1 !== 5'd0 || sel2 !== 5'd0) begin bad++; $display("FAIL fl_sel got=%0d/%0d exp=0/0", sel1, sel2); end
        tick();
        idle();
        #1;
        total++; if (v1 !== 1'b0 || v2 !== 1'b0 || dr !== 1'b1) begin bad++; $display("FAIL fl_after got=%0h%0h%0h exp=001", v1, v2, dr); end
        disp1(0, 1, 0, 1, 12, 0, 32'hF1);
        tick();
        idle();
        #1;
        total++; if (v1 !== 1'b1 || p1 !== 32'hF1 || sel1 !== 5'd0) begin bad++; $display("FAIL nowe_issue got=%0h/%0h/%0d exp=1/f1/0", v1, p1, sel1); end
        tick();
    endtask

    task automatic test_random;
        ment_t mq[$];
        ment_t nq[$];
        ment_t e;
        int rdy[$];
        int i1, i2;
        bit e1, e2, edr;
        logic [PW-1:0] ep1, ep2;
        logic [4:0] es1, es2, t3, t4;
        clear_q();
        for (int c = 0; c < 1500; c++) begin
            flush = ($urandom_range(0, 59) == 0);
            d1v = ($urandom_range(0, 2) != 0);
            d2v = d1v && ($urandom_range(0, 1) == 1);
            d1s1 = 5'($urandom_range(0, 7)); d1s2 = 5'($urandom_range(0, 7)); d1d = 5'($urandom_range(0, 7));
            d2s1 = 5'($urandom_range(0, 7)); d2s2 = 5'($urandom_range(0, 7)); d2d = 5'($urandom_range(0, 7));
            d1r1 = ($urandom_range(0, 2) == 0); d1r2 = ($urandom_range(0, 2) == 0);
            d2r1 = ($urandom_range(0, 2) == 0); d2r2 = ($urandom_range(0, 2) == 0);
            d1we = ($urandom_range(0, 3) != 0); d2we = ($urandom_range(0, 3) != 0);
            d1pl = $urandom; d2pl = $urandom;
            wb1 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'd0;
            wb2 = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 7)) : 5'd0;
            ir1 = ($urandom_range(0, 3) != 0); ir2 = ($urandom_range(0, 3) != 0);
            #1;
            rdy.delete();
            foreach (mq[j]) if (mq[j].r1 && mq[j].r2) rdy.push_back(j);
            e1 = !flush && ir1 && rdy.size() >= 1;
            e2 = !flush && ir2 && (ir1 ? rdy.size() >= 2 : rdy.size() >= 1);
            i1 = e1 ? rdy[0] : -1;
            i2 = e2 ? (ir1 ? rdy[1] : rdy[0]) : -1;
            ep1 = e1 ? mq[i1].pl : '0;
            ep2 = e2 ? mq[i2].pl : '0;
            es1 = (e1 && mq[i1].we) ? mq[i1].dst : 5'd0;
            es2 = (e2 && mq[i2].we) ? mq[i2].dst : 5'd0;
            edr = (D - mq.size()) >= 2;
            total++; if (v1 !== e1) begin bad++; $display("FAIL rnd_v1 cyc=%0d got=%0h exp=%0h", c, v1, e1); end
            total++; if (v2 !== e2) begin bad++; $display("FAIL rnd_v2 cyc=%0d got=%0h exp=%0h", c, v2, e2); end
            total++; if (p1 !== ep1) begin bad++; $display("FAIL rnd_p1 cyc=%0d got=%0h exp=%0h", c, p1, ep1); end
            total++; if (p2 !== ep2) begin bad++; $display("FAIL rnd_p2 cyc=%0d got=%0h exp=%0h", c, p2, ep2); end
            total++; if (sel1 !== es1) begin bad++; $display("FAIL rnd_sel1 cyc=%0d got=%0d exp=%0d", c, sel1, es1); end
            total++; if (sel2 !== es2) begin bad++; $display("FAIL rnd_sel2 cyc=%0d got=%0d exp=%0d", c, sel2, es2); end
            total++; if (dr !== edr) begin bad++; $display("FAIL rnd_dr cyc=%0d got=%0h exp=%0h", c, dr, edr); end
`ifdef ISSUE_SPEC_WAKEUP_EN
            t3 = es1; t4 = es2;
`else
            t3 = 0; t4 = 0;
`endif
            if (flush) mq.delete();
            else begin
                nq.delete();
                foreach (mq[j]) if (j != i1 && j != i2) begin
                    e = mq[j];
                    e.r1 = e.r1 || hit(e.s1, wb1, wb2, t3, t4);
                    e.r2 = e.r2 || hit(e.s2, wb1, wb2, t3, t4);
                    nq.push_back(e);
                end
                if (edr && d1v) nq.push_back('{s1: d1s1, s2: d1s2, dst: d1d, we: d1we, pl: d1pl,
                    r1: d1r1 || d1s1 == 0 || hit(d1s1, wb1, wb2, t3, t4),
                    r2: d1r2 || d1s2 == 0 || hit(d1s2, wb1, wb2, t3, t4)});
                if (edr && d2v) nq.push_back('{s1: d2s1, s2: d2s2, dst: d2d, we: d2we, pl: d2pl,
                    r1: d2r1 || d2s1 == 0 || hit(d2s1, wb1, wb2, t3, t4),
                    r2: d2r2 || d2s2 == 0 || hit(d2s2, wb1, wb2, t3, t4)});
                mq = nq;
            end
            tick();
        end
        idle();
    endtask

    initial begin
        #1;
        test_reset();
        test_two_ready();
        test_wb_wakeup();
        test_full();
        test_port2_only();
        test_back_to_back();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
